// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch stage. Issues PC-ordered requests
// under a credit limit, queues in-order responses tagged with their PC, and
// handles branch redirects by flushing the queue and dropping stale responses.

module fetch_unit_checker #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input logic             clk,
    input logic             reset,
    input logic             imem_resp_valid,
    input logic [CNT_W-1:0] outstanding,
    input logic [CNT_W-1:0] q_count
);
    // A response while nothing is in flight is a memory protocol violation
    a_resp_without_request: assert property (@(posedge clk) disable iff (reset)
        !(imem_resp_valid && (outstanding == '0)));

    // Queued entries plus in-flight requests never exceed the queue capacity
    a_credit_bound: assert property (@(posedge clk) disable iff (reset)
        (({1'b0, q_count} + {1'b0, outstanding}) <= (CNT_W+1)'(DEPTH)));
endmodule

module fetch_unit #(
    parameter int                ADDR_W   = 64,
    parameter int                INSTR_W  = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     PCSrc_F,
    input  logic [ADDR_W-1:0]        PCBranch_F,
    output logic                     imem_req_valid,
    input  logic                     imem_req_ready,
    output logic [ADDR_W-1:0]        imem_addr_F,
    input  logic                     imem_resp_valid,
    input  logic [INSTR_W-1:0]       imem_resp_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INSTR_W-1:0]       out_instr,
    output logic [ADDR_W-1:0]        out_pc,
    output logic [$clog2(DEPTH):0]   q_count
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = ADDR_W + INSTR_W;

    localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(PC_STEP);
    localparam logic [CNT_W:0]    CAP     = (CNT_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1'b1);
    localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1'b1);

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t              state_r;
    logic [ADDR_W-1:0]   pc_r;
    logic [ADDR_W-1:0]   resp_pc_r;
    logic [CNT_W-1:0]    outstanding_r;
    logic [CNT_W-1:0]    drop_cnt_r;
    logic [ENTRY_W-1:0]  mem_r [DEPTH];
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [CNT_W-1:0]    count_r;
    logic                out_valid_r;
    logic [INSTR_W-1:0]  out_instr_r;
    logic [ADDR_W-1:0]   out_pc_r;

    logic                credit_ok_s;
    logic                req_fire_s;
    logic                resp_legal_s;
    logic                enq_s;
    logic                deq_s;
    logic [CNT_W:0]      inflight_s;
    logic [CNT_W-1:0]    outstanding_nxt_s;
    logic [CNT_W-1:0]    count_after_pop_s;
    logic [CNT_W-1:0]    count_nxt_s;
    logic [PTR_W-1:0]    rd_after_pop_s;
    logic [ENTRY_W-1:0]  enq_entry_s;
    logic [ENTRY_W-1:0]  head_nxt_s;

    // A request is offered only when a queue slot is reserved for its response
    assign imem_req_valid = !reset && !PCSrc_F && credit_ok_s;
    assign imem_addr_F    = pc_r;
    assign out_valid      = out_valid_r;
    assign out_instr      = out_instr_r;
    assign out_pc         = out_pc_r;
    assign q_count        = count_r;

    // Handshake qualification; responses with nothing in flight are ignored
    always_comb begin
        inflight_s   = {1'b0, count_r} + {1'b0, outstanding_r};
        credit_ok_s  = (inflight_s < CAP);
        req_fire_s   = imem_req_valid && imem_req_ready;
        resp_legal_s = imem_resp_valid && (outstanding_r != '0);
        deq_s        = out_valid_r && out_ready;
        enq_s        = resp_legal_s && (state_r == FETCH) && !PCSrc_F;
        enq_entry_s  = {resp_pc_r, imem_resp_data};
    end

    // In-flight count: accepted requests add one, consumed responses remove one
    always_comb begin
        case ({req_fire_s, resp_legal_s})
            2'b10:   outstanding_nxt_s = outstanding_r + CNT_ONE;
            2'b01:   outstanding_nxt_s = outstanding_r - CNT_ONE;
            default: outstanding_nxt_s = outstanding_r;
        endcase
    end

    // Occupancy after this cycle's pop/push and the entry that becomes the head
    always_comb begin
        count_after_pop_s = count_r - CNT_W'(deq_s);
        rd_after_pop_s    = rd_ptr_r + PTR_W'(deq_s);
        count_nxt_s       = count_after_pop_s + CNT_W'(enq_s);
        if (count_after_pop_s == '0) begin
            // Queue is empty after the pop: the incoming response is the new head
            head_nxt_s = enq_entry_s;
        end else begin
            head_nxt_s = mem_r[rd_after_pop_s];
        end
    end

    // PC, response tag, in-flight counters and the fetch/flush state machine
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r          <= RESET_PC;
            resp_pc_r     <= RESET_PC;
            outstanding_r <= '0;
            drop_cnt_r    <= '0;
            state_r       <= FETCH;
        end else if (PCSrc_F) begin
            // Everything still in flight after this edge belongs to the old path
            pc_r          <= PCBranch_F;
            resp_pc_r     <= PCBranch_F;
            outstanding_r <= outstanding_nxt_s;
            drop_cnt_r    <= outstanding_nxt_s;
            state_r       <= (outstanding_nxt_s != '0) ? FLUSH : FETCH;
        end else begin
            outstanding_r <= outstanding_nxt_s;
            if (req_fire_s) begin
                pc_r <= pc_r + STEP;
            end
            case (state_r)
                FETCH: begin
                    if (resp_legal_s) begin
                        resp_pc_r <= resp_pc_r + STEP;
                    end
                end
                FLUSH: begin
                    if (resp_legal_s) begin
                        drop_cnt_r <= drop_cnt_r - CNT_ONE;
                        if (drop_cnt_r == CNT_ONE) begin
                            state_r <= FETCH;
                        end
                    end else if (drop_cnt_r == '0) begin
                        state_r <= FETCH;
                    end
                end
                default: begin
                    state_r    <= FETCH;
                    drop_cnt_r <= '0;
                end
            endcase
        end
    end

    // Response queue storage, pointers and the registered head outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            rd_ptr_r    <= '0;
            wr_ptr_r    <= '0;
            count_r     <= '0;
            out_valid_r <= 1'b0;
            out_instr_r <= '0;
            out_pc_r    <= '0;
        end else if (PCSrc_F) begin
            // Flush; head value registers keep their last contents
            rd_ptr_r    <= '0;
            wr_ptr_r    <= '0;
            count_r     <= '0;
            out_valid_r <= 1'b0;
        end else begin
            if (enq_s) begin
                mem_r[wr_ptr_r] <= enq_entry_s;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            rd_ptr_r    <= rd_after_pop_s;
            count_r     <= count_nxt_s;
            out_valid_r <= (count_nxt_s != '0);
            if (count_nxt_s != '0) begin
                out_pc_r    <= head_nxt_s[ENTRY_W-1 -: ADDR_W];
                out_instr_r <= head_nxt_s[INSTR_W-1:0];
            end
        end
    end

    fetch_unit_checker #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_checker (
        .clk             (clk),
        .reset           (reset),
        .imem_resp_valid (imem_resp_valid),
        .outstanding     (outstanding_r),
        .q_count         (count_r)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a 64-bit instance driven by a latency-
// configurable in-order memory model, plus a 16-bit instance for PC wrap.

module tb_fetch_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        PCSrc_F;
    logic [63:0] PCBranch_F;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_addr_F;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic [2:0]  q_count;

    logic        w_pcsrc;
    logic [15:0] w_branch;
    logic        w_req_valid;
    logic        w_req_ready;
    logic [15:0] w_addr;
    logic        w_resp_valid;
    logic [31:0] w_resp_data;
    logic        w_out_valid;
    logic        w_out_ready;
    logic [31:0] w_out_instr;
    logic [15:0] w_out_pc;
    logic [2:0]  w_q_count;

    fetch_unit dut (
        .clk(clk), .reset(reset), .PCSrc_F(PCSrc_F), .PCBranch_F(PCBranch_F),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr_F(imem_addr_F), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .q_count(q_count)
    );

    fetch_unit #(.ADDR_W(16), .RESET_PC(16'hFFFC)) dut16 (
        .clk(clk), .reset(reset), .PCSrc_F(w_pcsrc), .PCBranch_F(w_branch),
        .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready),
        .imem_addr_F(w_addr), .imem_resp_valid(w_resp_valid),
        .imem_resp_data(w_resp_data), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out_instr(w_out_instr), .out_pc(w_out_pc), .q_count(w_q_count)
    );

    typedef struct {
        logic [63:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    logic [63:0] delivered[$];
    int          lat = 1;
    int          cyc = 0;
    int          accepts = 0;
    int          errors = 0;
    int          checks = 0;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes before the edge, update the memory model after it
    task automatic cycle();
        logic        accepted;
        logic [63:0] acc_addr;
        logic        consumed;
        logic        del_now;
        logic [63:0] del_pc;
        #1;
        accepted = imem_req_valid && imem_req_ready;
        acc_addr = imem_addr_F;
        consumed = imem_resp_valid;
        del_now  = out_valid && out_ready;
        del_pc   = out_pc;
        @(posedge clk);
        cyc++;
        #1;
        if (consumed && (pend.size() > 0)) void'(pend.pop_front());
        if (accepted) begin
            pend.push_back('{addr: acc_addr, due: cyc + lat - 1});
            accepts++;
        end
        if (del_now) delivered.push_back(del_pc);
        if ((pend.size() > 0) && (pend[0].due <= cyc)) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = instr_of(pend[0].addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
        end
        @(negedge clk);
    endtask

    task automatic clear_model();
        pend.delete();
        delivered.delete();
        accepts         = 0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_model();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; PCSrc_F = 1'b0; PCBranch_F = 64'h0; imem_req_ready = 1'b0;
        imem_resp_valid = 1'b0; imem_resp_data = 32'h0; out_ready = 1'b0;
        w_pcsrc = 1'b0; w_branch = 16'h0; w_req_ready = 1'b0;
        w_resp_valid = 1'b0; w_resp_data = 32'h0; w_out_ready = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_req_valid", 64'(imem_req_valid), 64'h0);
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_q_count", 64'(q_count), 64'h0);
        check("rst_out_pc", out_pc, 64'h0);
        check("rst_out_instr", 64'(out_instr), 64'h0);
        check("rst_addr", imem_addr_F, 64'h0);
        check("rst_addr16", 64'(w_addr), 64'hFFFC);
        reset = 1'b0;
        #1;
        check("post_rst_req_valid", 64'(imem_req_valid), 64'h1);

        // Streaming with a 1-cycle memory
        lat = 1; imem_req_ready = 1'b1; out_ready = 1'b1;
        cycle();
        check("stream_latency", 64'(out_valid), 64'h0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check($sformatf("stream_valid%0d", i), 64'(out_valid), 64'h1);
            check($sformatf("stream_pc%0d", i), out_pc, 64'(4 * i));
            check($sformatf("stream_instr%0d", i), 64'(out_instr), 64'(instr_of(64'(4 * i))));
        end

        // Back-pressure: credits limit accepted requests to the queue depth
        do_reset();
        out_ready = 1'b0;
        repeat (8) cycle();
        check("full_accepts", 64'(accepts), 64'd4);
        check("full_q_count", 64'(q_count), 64'd4);
        check("full_req_valid", 64'(imem_req_valid), 64'h0);
        check("full_head_pc", out_pc, 64'h0);
        out_ready = 1'b1;
        #1;
        check("full_credit_not_yet", 64'(imem_req_valid), 64'h0);
        cycle();
        check("drain_pc", out_pc, 64'h4);
        check("drain_q_count", 64'(q_count), 64'd3);
        check("drain_req_valid", 64'(imem_req_valid), 64'h1);
        check("drain_addr", imem_addr_F, 64'h10);
        cycle();
        check("resume_accepts", 64'(accepts), 64'd5);

        // Redirect with two requests in flight on a 3-cycle memory
        do_reset();
        lat = 3; imem_req_ready = 1'b1; out_ready = 1'b1;
        cycle();
        cycle();
        imem_req_ready = 1'b0;
        PCSrc_F = 1'b1; PCBranch_F = 64'h1000;
        #1;
        check("redir_no_req", 64'(imem_req_valid), 64'h0);
        cycle();
        PCSrc_F = 1'b0; imem_req_ready = 1'b1;
        #1;
        check("redir_addr", imem_addr_F, 64'h1000);
        check("redir_q_count", 64'(q_count), 64'h0);
        check("redir_out_valid", 64'(out_valid), 64'h0);
        check("redir_drop_cnt", 64'(dut.drop_cnt_r), 64'd2);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check($sformatf("redir_no_stale%0d", i), 64'(out_valid), 64'h0);
        end
        cycle();
        check("redir_first_valid", 64'(out_valid), 64'h1);
        check("redir_first_pc", out_pc, 64'h1000);
        check("redir_first_instr", 64'(out_instr), 64'(instr_of(64'h1000)));

        // Redirect coinciding with a response and a dequeue
        do_reset();
        lat = 2; imem_req_ready = 1'b1; out_ready = 1'b1;
        cycle();
        cycle();
        cycle();
        check("coin_pre_valid", 64'(out_valid), 64'h1);
        check("coin_pre_resp", 64'(imem_resp_valid), 64'h1);
        PCSrc_F = 1'b1; PCBranch_F = 64'h2000;
        #1;
        check("coin_no_req", 64'(imem_req_valid), 64'h0);
        cycle();
        PCSrc_F = 1'b0;
        check("coin_drop_cnt", 64'(dut.drop_cnt_r), 64'd1);
        check("coin_q_count", 64'(q_count), 64'h0);
        check("coin_delivered_n", 64'(delivered.size()), 64'd1);
        check("coin_delivered_pc", (delivered.size() > 0) ? delivered[0] : 64'hDEAD, 64'h0);
        cycle();
        check("coin_no_stale0", 64'(out_valid), 64'h0);
        cycle();
        check("coin_no_stale1", 64'(out_valid), 64'h0);
        cycle();
        check("coin_first_valid", 64'(out_valid), 64'h1);
        check("coin_first_pc", out_pc, 64'h2000);

        // 16-bit build wraps the PC past 0xFFFC
        w_req_ready = 1'b1;
        #1;
        check("wrap_req_valid", 64'(w_req_valid), 64'h1);
        check("wrap_addr0", 64'(w_addr), 64'hFFFC);
        cycle();
        check("wrap_addr1", 64'(w_addr), 64'h0000);
        cycle();
        check("wrap_addr2", 64'(w_addr), 64'h0004);
        w_req_ready = 1'b0;

        // Asynchronous reset in the middle of a burst with three in flight
        lat = 3;
        for (int i = 0; i < 12; i++) begin
            if (pend.size() == 3) break;
            cycle();
        end
        check("burst_outstanding", 64'(pend.size()), 64'd3);
        reset = 1'b1;
        #1;
        check("mid_rst_req_valid", 64'(imem_req_valid), 64'h0);
        check("mid_rst_out_valid", 64'(out_valid), 64'h0);
        check("mid_rst_q_count", 64'(q_count), 64'h0);
        check("mid_rst_out_pc", out_pc, 64'h0);
        check("mid_rst_out_instr", 64'(out_instr), 64'h0);
        check("mid_rst_addr", imem_addr_F, 64'h0);
        check("mid_rst_addr16", 64'(w_addr), 64'hFFFC);
        clear_model();
        @(negedge clk);
        reset = 1'b0;
        lat = 1;
        #1;
        check("post_mid_rst_addr", imem_addr_F, 64'h0);
        cycle();
        cycle();
        check("post_mid_rst_valid", 64'(out_valid), 64'h1);
        check("post_mid_rst_pc", out_pc, 64'h0);
        check("post_mid_rst_instr", 64'(out_instr), 64'(instr_of(64'h0)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
